// File: rtl/dbus_pkg.sv
// Shared definitions for the data-bus interconnect: region-decode defaults,
// read-pipeline entry layout and small helpers.
package dbus_pkg;

   localparam int DEF_SEL_LSB   = 11;
   localparam int DEF_SEL_WIDTH = 2;
   // Pipeline entries carry a fixed-width index so every instance shares one layout.
   localparam int IDX_MAX_W     = 8;

   typedef logic [IDX_MAX_W-1:0] region_idx_t;

   typedef struct packed {
      logic        valid;
      logic        mapped;
      region_idx_t index;
   } rd_entry_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/dbus_rd_tracker.sv
// Fixed-latency shift pipeline that remembers which region each read targeted,
// presenting the entry exactly RD_LATENCY cycles after issue.
module dbus_rd_tracker
   import dbus_pkg::*;
#(
   parameter int RD_LATENCY = 1,
   parameter int SEL_WIDTH  = DEF_SEL_WIDTH
) (
   input  logic                 CLK,
   input  logic                 RESET_N,
   input  logic                 CLEAR,
   input  logic                 issue_valid,
   input  logic                 issue_mapped,
   input  logic [SEL_WIDTH-1:0] issue_index,
   output logic                 ret_valid,
   output logic                 ret_mapped,
   output logic [IDX_MAX_W-1:0] ret_index
);

   rd_entry_t [RD_LATENCY-1:0] pipe_reg;
   rd_entry_t                  issue_next;

   always_comb begin
      issue_next        = '0;
      issue_next.valid  = issue_valid;
      issue_next.mapped = issue_mapped;
      issue_next.index  = IDX_MAX_W'(issue_index);
   end

   // CLEAR also drops a read issued in the same cycle.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         pipe_reg <= '0;
      end else if (CLEAR) begin
         pipe_reg <= '0;
      end else begin
         pipe_reg[0] <= issue_next;
         for (int i = 1; i < RD_LATENCY; i++) pipe_reg[i] <= pipe_reg[i-1];
      end
   end

   assign ret_valid  = pipe_reg[RD_LATENCY-1].valid;
   assign ret_mapped = pipe_reg[RD_LATENCY-1].mapped;
   assign ret_index  = pipe_reg[RD_LATENCY-1].index;

endmodule

// File: rtl/mux.sv
// Generic N-way word multiplexer; a select outside 0..N-1 yields zero.
module mux #(
   parameter int N     = 2,
   parameter int W     = 32,
   parameter int SEL_W = 1
) (
   input  logic [N*W-1:0] din,
   input  logic [SEL_W-1:0] sel,
   output logic [W-1:0]   dout
);

   always_comb begin
      dout = '0;
      for (int i = 0; i < N; i++) begin
         if (sel == SEL_W'(i)) dout = din[i*W +: W];
      end
   end

endmodule

// File: rtl/dbus_interconnect.sv
// Core data-bus interconnect: decodes the address into one-hot slave strobes,
// returns read data after a fixed latency and records unmapped accesses.
module dbus_interconnect
   import dbus_pkg::*;
#(
   parameter int DATA_SIZE  = 32,
   parameter int ADDR_SIZE  = 13,
   parameter int N_SLAVES   = 4,
   parameter int SEL_LSB    = DEF_SEL_LSB,
   parameter int SEL_WIDTH  = DEF_SEL_WIDTH,
   parameter int RD_LATENCY = 1
) (
   input  logic                          CLK,
   input  logic                          RESET_N,
   input  logic                          CLEAR,
   input  logic                          mem_write,
   input  logic                          mem_read,
   input  logic [ADDR_SIZE-1:0]          daddr,
   input  logic [DATA_SIZE-1:0]          ddata_w,
   output logic [DATA_SIZE-1:0]          ddata_r,
   output logic                          rd_valid,
   output logic [N_SLAVES-1:0]           s_write,
   output logic [N_SLAVES-1:0]           s_read,
   output logic [SEL_LSB-1:0]            s_addr,
   output logic [DATA_SIZE-1:0]          s_wdata,
   input  logic [N_SLAVES*DATA_SIZE-1:0] s_rdata,
   output logic                          bus_err,
   output logic [ADDR_SIZE-1:0]          err_addr,
   output logic [7:0]                    err_count
);

   logic [SEL_WIDTH-1:0] region_idx;
   logic                 mapped;
   logic                 unmapped_acc;

   assign region_idx   = daddr[SEL_LSB +: SEL_WIDTH];
   assign mapped       = (32'(region_idx) < N_SLAVES);
   assign unmapped_acc = (mem_read || mem_write) && !mapped;

   // An unmapped index never equals any gi below N_SLAVES, so it strobes nothing.
   for (genvar gi = 0; gi < N_SLAVES; gi++) begin : g_strobe
      assign s_write[gi] = mem_write && (region_idx == SEL_WIDTH'(gi));
      assign s_read[gi]  = mem_read  && (region_idx == SEL_WIDTH'(gi));
   end

   assign s_addr  = daddr[SEL_LSB-1:0];
   assign s_wdata = ddata_w;

   logic                 ret_valid;
   logic                 ret_mapped;
   logic [IDX_MAX_W-1:0] ret_index;
   logic [DATA_SIZE-1:0] mux_data;

   dbus_rd_tracker #(
      .RD_LATENCY (RD_LATENCY),
      .SEL_WIDTH  (SEL_WIDTH)
   ) u_tracker (
      .CLK          (CLK),
      .RESET_N      (RESET_N),
      .CLEAR        (CLEAR),
      .issue_valid  (mem_read),
      .issue_mapped (mapped),
      .issue_index  (region_idx),
      .ret_valid    (ret_valid),
      .ret_mapped   (ret_mapped),
      .ret_index    (ret_index)
   );

   mux #(
      .N     (N_SLAVES),
      .W     (DATA_SIZE),
      .SEL_W (IDX_MAX_W)
   ) u_rd_mux (
      .din  (s_rdata),
      .sel  (ret_index),
      .dout (mux_data)
   );

   assign rd_valid = ret_valid;
   assign ddata_r  = (ret_valid && ret_mapped) ? mux_data : '0;

   logic                 bus_err_reg;
   logic [ADDR_SIZE-1:0] err_addr_reg;
   logic [7:0]           err_count_reg;
   logic [7:0]           err_count_next;

   assign err_count_next = sat_inc8(err_count_reg);

   // Only the first unmapped address is kept until CLEAR.
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         bus_err_reg   <= 1'b0;
         err_addr_reg  <= '0;
         err_count_reg <= '0;
      end else if (CLEAR) begin
         bus_err_reg   <= 1'b0;
         err_addr_reg  <= '0;
         err_count_reg <= '0;
      end else if (unmapped_acc) begin
         bus_err_reg   <= 1'b1;
         if (!bus_err_reg) err_addr_reg <= daddr;
         err_count_reg <= err_count_next;
      end
   end

   assign bus_err   = bus_err_reg;
   assign err_addr  = err_addr_reg;
   assign err_count = err_count_reg;

endmodule
